avalon_pio_setclr_edge: RTL and testbench
=========================================

Name: avalon_pio_setclr_edge

Overview:
Parametrised Avalon-MM slave PIO, successor to the fixed 4-bit write-only output port used for colour selection. It provides:
- an output register of configurable width, with atomic bit-set and bit-clear aliases;
- a synchronised input port with per-bit rising/falling edge capture;
- a level interrupt gated by a mask.

It sits on the HPS/Nios lightweight bus, alongside the other PIOs in the Qsys system.

Parameters:
DATA_WIDTH, 8, output register width (1..32)
OUT_RESET, 0, reset value of the output register (DATA_WIDTH bits)
IN_WIDTH, 4, input port width (1..32)
SYNC_STAGES, 2, flip-flop stages on in_port (2..4)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
address  in  3  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits above the register width are ignored
readdata  out  32  read data, zero-extended, combinational (zero wait states)
out_port  out  DATA_WIDTH  output register value
in_port  in  IN_WIDTH  asynchronous inputs
irq  out  1  registered interrupt request

Behaviour:
- Single clock domain. Reset is synchronous and active-low: when reset_n=0 at a rising clk edge, every register loads its reset value.
- Reset values:
  - out_port = OUT_RESET; irq = 0.
  - irq_mask, edge_sel, edge_capture, synchroniser chain and prime counter all = 0.
- Write strobe: wr = chipselect & ~write_n. A write takes effect on the clk edge where wr=1.
- Address map (reads are combinational; write effect in brackets):
  - 0 DATA: read = out register. [load writedata[DATA_WIDTH-1:0]]
  - 1 IN: read = synchronised input (final sync stage). [no effect]
  - 2 IRQ_MASK: read/write, IN_WIDTH bits.
  - 3 EDGE_CAPTURE: read = captured bits. [write-1-to-clear per bit]
  - 4 OUTSET: read = 0. [out <= out | wd]
  - 5 OUTCLR: read = 0. [out <= out & ~wd]
  - 6 EDGE_SEL: read/write, IN_WIDTH bits. Per bit: 0 = rising edge, 1 = falling edge.
  - 7 reserved: read = 0, writes ignored.
- readdata = 0 whenever chipselect=0.
- out_port is driven directly by the register: a write at edge N is visible after edge N.
- Input path: in_port passes through SYNC_STAGES flops (s_last), then one further delay flop (s_prev).
  - rise = s_last & ~s_prev
  - fall = ~s_last & s_prev
  - hit[i] = edge_sel[i] ? fall[i] : rise[i]
- Latency: an in_port transition that meets setup before edge N sets edge_capture on edge N+SYNC_STAGES.
- Priming after reset:
  - A counter counts SYNC_STAGES+1 cycles after reset_n goes high; hit is forced to 0 until it saturates.
  - Inputs held high through reset therefore never produce a spurious rising capture.
  - The IN register still reads the live synchronised value during priming.
- edge_capture update each cycle: cap <= (cap & ~clr) | hit, where clr = writedata bits when writing address 3, else 0.
  - If a write-1-clear and a new hit land on the same bit in the same cycle, the hit wins and the bit stays 1.
- Changing EDGE_SEL does not modify edge_capture; the new polarity applies from the next cycle.
- irq is registered: irq <= |(edge_capture & irq_mask), evaluated from the current-cycle register values. It deasserts one cycle after the last enabled capture bit is cleared or masked.
- A reset asserted mid-transfer aborts the write; all state returns to reset values on that edge.

Test Plan:
1. Reset with DATA_WIDTH=8, OUT_RESET=8'hA5, in_port held 4'hF through reset release:
   - out_port=8'hA5, irq=0.
   - edge_capture reads 0 for 10 cycles after release (no spurious rising edges).
   - IN reads 4'hF after SYNC_STAGES cycles.
2. Output aliases:
   - Write 0x3C to addr 0 -> out_port=0x3C.
   - Write 0x81 to addr 4 -> 0xBD.
   - Write 0x0C to addr 5 -> 0xB1.
   - Reads of addr 4 and addr 5 return 0.
   - Write 0xFFFF_FF00 to addr 0 -> out_port=0x00.
3. Edge polarity:
   - Write EDGE_SEL=4'b0010.
   - Pulse in_port[0] 0->1->0 and in_port[1] 0->1->0 -> edge_capture=4'b0011.
   - Bit0 sets 2 cycles after the rise; bit1 sets 2 cycles after the fall.
4. Interrupt:
   - IRQ_MASK=4'b0001, edge_capture=4'b0011 -> irq=1 one cycle later.
   - Write 4'b0001 to addr 3 -> capture=4'b0010 and irq=0 one cycle after the capture changes.
   - IRQ_MASK=0 with captures pending -> irq stays 0.
5. Clear/hit collision: write 1 to addr 3 bit 2 in the same cycle a synchronised rising edge on bit 2 arrives -> bit 2 reads 1.
6. Reset mid-operation:
   - Assert reset_n=0 for one cycle during a write of 0xFF to addr 0 while edge_capture=4'hF.
   - Required result: out_port=OUT_RESET, edge_capture=0, irq=0.
   - Writes to addr 7 read back 0.

Source files
------------

// File: rtl/avalon_pio_setclr_edge_if.sv
// Avalon-MM slave bus bundle for the set/clear/edge PIO: word address,
// select, active-low write strobe and 32-bit data paths.
interface avalon_pio_setclr_edge_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_pio_setclr_edge.sv
// Avalon-MM slave PIO: output register with atomic set/clear aliases,
// synchronised inputs with per-bit edge capture, and a masked level interrupt.
module avalon_pio_setclr_edge #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET   = '0,
  parameter int                    IN_WIDTH    = 4,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  avalon_pio_setclr_edge_if.slave bus,
  output logic [DATA_WIDTH-1:0]   out_port,
  input  logic [IN_WIDTH-1:0]     in_port,
  output logic                    irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_IN      = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam logic [2:0] ADDR_EDGESEL = 3'd6;

  localparam int PRIME_MAX = SYNC_STAGES + 1;
  localparam int PRIME_W   = $clog2(PRIME_MAX + 1);

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd_out;
  logic [IN_WIDTH-1:0]   wd_in;
  logic [DATA_WIDTH-1:0] out_reg;
  logic [DATA_WIDTH-1:0] out_next;
  logic [IN_WIDTH-1:0]   irq_mask;
  logic [IN_WIDTH-1:0]   edge_sel;
  logic [IN_WIDTH-1:0]   edge_capture;
  logic [IN_WIDTH-1:0]   sync_chain [SYNC_STAGES];
  logic [IN_WIDTH-1:0]   s_last;
  logic [IN_WIDTH-1:0]   s_prev;
  logic [IN_WIDTH-1:0]   rise;
  logic [IN_WIDTH-1:0]   fall;
  logic [IN_WIDTH-1:0]   hit;
  logic [IN_WIDTH-1:0]   cap_clr;
  logic [PRIME_W-1:0]    prime_cnt;
  logic                  primed;
  logic [31:0]           rdata;
  logic                  unused_writedata;

  assign wr     = bus.chipselect & ~bus.write_n;
  assign wd_out = bus.writedata[DATA_WIDTH-1:0];
  assign wd_in  = bus.writedata[IN_WIDTH-1:0];

  // Bits of writedata above either register width are deliberately ignored.
  assign unused_writedata = &{1'b0, bus.writedata};

  always_comb begin
    out_next = out_reg;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:   out_next = wd_out;
        ADDR_OUTSET: out_next = out_reg | wd_out;
        ADDR_OUTCLR: out_next = out_reg & ~wd_out;
        default:     out_next = out_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_reg <= OUT_RESET;
    end else begin
      out_reg <= out_next;
    end
  end

  assign out_port = out_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= '0;
      end
      s_prev <= '0;
    end else begin
      sync_chain[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= sync_chain[i-1];
      end
      s_prev <= s_last;
    end
  end

  assign s_last = sync_chain[SYNC_STAGES-1];

  // Edge detection stays blind until the chain and s_prev hold real samples,
  // so inputs already high at reset release never look like rising edges.
  assign primed = (prime_cnt == PRIME_W'(PRIME_MAX));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prime_cnt <= '0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + PRIME_W'(1);
    end
  end

  assign rise    = s_last & ~s_prev;
  assign fall    = ~s_last & s_prev;
  assign hit     = primed ? ((edge_sel & fall) | (~edge_sel & rise)) : '0;
  assign cap_clr = (wr && bus.address == ADDR_CAPTURE) ? wd_in : '0;

  // A hit in the same cycle as its write-1-clear wins, so no edge is lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_sel     <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr && bus.address == ADDR_MASK) begin
        irq_mask <= wd_in;
      end
      if (wr && bus.address == ADDR_EDGESEL) begin
        edge_sel <= wd_in;
      end
      edge_capture <= (edge_capture & ~cap_clr) | hit;
      irq          <= |(edge_capture & irq_mask);
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.chipselect) begin
      case (bus.address)
        ADDR_DATA:    rdata[DATA_WIDTH-1:0] = out_reg;
        ADDR_IN:      rdata[IN_WIDTH-1:0]   = s_last;
        ADDR_MASK:    rdata[IN_WIDTH-1:0]   = irq_mask;
        ADDR_CAPTURE: rdata[IN_WIDTH-1:0]   = edge_capture;
        ADDR_EDGESEL: rdata[IN_WIDTH-1:0]   = edge_sel;
        default:      rdata = '0;
      endcase
    end
  end

  assign bus.readdata = rdata;

endmodule

// File: tb/tb_avalon_pio_setclr_edge.sv
// Self-checking bench for avalon_pio_setclr_edge: expected values are queued
// when stimulus is applied and popped when the DUT output is sampled.
module tb_avalon_pio_setclr_edge;
  localparam int         DATA_WIDTH  = 8;
  localparam logic [7:0] OUT_RESET   = 8'hA5;
  localparam int         IN_WIDTH    = 4;
  localparam int         SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] out_port;
  logic [3:0] in_port = 4'hF;
  logic       irq;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] exp_q [$];

  avalon_pio_setclr_edge_if bus ();

  avalon_pio_setclr_edge #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_RESET  (OUT_RESET),
    .IN_WIDTH   (IN_WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .out_port(out_port),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = addr;
    #1;
    data = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = addr;
    bus.writedata  = data;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp;
    reset_n = 1'b0;
    in_port = 4'hF;
    exp_q.push_back({24'h0, OUT_RESET});
    exp_q.push_back(32'h0);
    tick(3);
    reset_n = 1'b1;
    exp = exp_q.pop_front();
    checks++;
    if ({24'h0, out_port} !== exp) $display("[TB] FAIL reset out_port: got %h, want %h", out_port, exp[7:0]);
    else passed++;
    exp = exp_q.pop_front();
    checks++;
    if ({31'h0, irq} !== exp) $display("[TB] FAIL reset irq: got %b, want %b", irq, exp[0]);
    else passed++;
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back((i >= SYNC_STAGES) ? 32'hF : 32'h0);
      exp_q.push_back(32'h0);
      tick();
      bus_read(3'd1, rd);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) $display("[TB] FAIL prime IN cycle %0d: got %h, want %h", i, rd, exp);
      else passed++;
      bus_read(3'd3, rd);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) $display("[TB] FAIL prime capture cycle %0d: got %h, want %h", i, rd, exp);
      else passed++;
    end
    // Falling inputs under the default rising polarity must not capture.
    in_port = 4'h0;
    exp_q.push_back(32'h0);
    tick(5);
    bus_read(3'd3, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) $display("[TB] FAIL fall ignored: got %h, want %h", rd, exp);
    else passed++;
  endtask

  task automatic test_output_aliases();
    logic [2:0]  addr [5];
    logic [31:0] data [5];
    logic [7:0]  model;
    logic [31:0] rd;
    logic [31:0] exp;
    addr  = '{3'd0, 3'd4, 3'd5, 3'd7, 3'd0};
    data  = '{32'h3C, 32'h81, 32'h0C, 32'hFFFF_FFFF, 32'hFFFF_FF00};
    model = OUT_RESET;
    for (int i = 0; i < 5; i++) begin
      case (addr[i])
        3'd0:    model = data[i][7:0];
        3'd4:    model = model | data[i][7:0];
        3'd5:    model = model & ~data[i][7:0];
        default: model = model;
      endcase
      exp_q.push_back({24'h0, model});
      exp_q.push_back({24'h0, model});
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      bus_write(addr[i], data[i]);
      exp = exp_q.pop_front();
      checks++;
      if ({24'h0, out_port} !== exp) $display("[TB] FAIL out_port step %0d: got %h, want %h", i, out_port, exp[7:0]);
      else passed++;
      bus_read(3'd0, rd);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) $display("[TB] FAIL DATA read step %0d: got %h, want %h", i, rd, exp);
      else passed++;
      bus_read(3'd4, rd);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) $display("[TB] FAIL OUTSET read step %0d: got %h, want %h", i, rd, exp);
      else passed++;
      bus_read(3'd5, rd);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) $display("[TB] FAIL OUTCLR read step %0d: got %h, want %h", i, rd, exp);
      else passed++;
    end
  endtask

  task automatic test_edge_polarity();
    logic [31:0] rd;
    logic [31:0] exp;
    bus_write(3'd3, 32'hF);
    bus_write(3'd6, 32'h2);
    exp_q.push_back(32'h2);
    bus_read(3'd6, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) $display("[TB] FAIL EDGE_SEL read: got %h, want %h", rd, exp);
    else passed++;
    // Both bits rise: only bit 0 (rising polarity) captures, two edges later.
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    in_port = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus_read(3'd3, rd);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) $display("[TB] FAIL rise capture cycle %0d: got %h, want %h", i + 1, rd, exp);
      else passed++;
    end
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h3);
    in_port = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus_read(3'd3, rd);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) $display("[TB] FAIL fall capture cycle %0d: got %h, want %h", i + 1, rd, exp);
      else passed++;
    end
  endtask

  task automatic test_interrupt();
    logic [31:0] rd;
    logic [31:0] exp;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    bus_write(3'd2, 32'h1);
    exp = exp_q.pop_front();
    checks++;
    if ({31'h0, irq} !== exp) $display("[TB] FAIL irq same cycle as mask: got %b, want %b", irq, exp[0]);
    else passed++;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if ({31'h0, irq} !== exp) $display("[TB] FAIL irq after mask: got %b, want %b", irq, exp[0]);
    else passed++;
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) $display("[TB] FAIL capture after clear: got %h, want %h", rd, exp);
    else passed++;
    exp = exp_q.pop_front();
    checks++;
    if ({31'h0, irq} !== exp) $display("[TB] FAIL irq at clear: got %b, want %b", irq, exp[0]);
    else passed++;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if ({31'h0, irq} !== exp) $display("[TB] FAIL irq after clear: got %b, want %b", irq, exp[0]);
    else passed++;
    exp_q.push_back(32'h1);
    bus_write(3'd2, 32'h2);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if ({31'h0, irq} !== exp) $display("[TB] FAIL irq on bit1 mask: got %b, want %b", irq, exp[0]);
    else passed++;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h2);
    bus_write(3'd2, 32'h0);
    tick(4);
    exp = exp_q.pop_front();
    checks++;
    if ({31'h0, irq} !== exp) $display("[TB] FAIL irq with mask 0: got %b, want %b", irq, exp[0]);
    else passed++;
    bus_read(3'd3, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) $display("[TB] FAIL capture pending: got %h, want %h", rd, exp);
    else passed++;
  endtask

  task automatic test_clear_hit_collision();
    logic [31:0] rd;
    logic [31:0] exp;
    exp_q.push_back(32'h6);
    exp_q.push_back(32'h2);
    in_port = 4'b0100;
    tick(2);
    bus_write(3'd3, 32'h4);
    bus_read(3'd3, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) $display("[TB] FAIL clear/hit collision: got %h, want %h", rd, exp);
    else passed++;
    bus_write(3'd3, 32'h4);
    bus_read(3'd3, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) $display("[TB] FAIL plain clear: got %h, want %h", rd, exp);
    else passed++;
  endtask

  task automatic test_reset_mid_op();
    logic [2:0]  addr [6];
    logic [31:0] rd;
    logic [31:0] exp;
    // Rising on bits 0/3/2 and falling on bit 1 fill every capture bit.
    in_port = 4'b1011;
    tick(3);
    in_port = 4'b0101;
    tick(3);
    exp_q.push_back(32'hF);
    exp_q.push_back(32'h1);
    bus_write(3'd2, 32'hF);
    tick();
    bus_read(3'd3, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) $display("[TB] FAIL pre-reset capture: got %h, want %h", rd, exp);
    else passed++;
    exp = exp_q.pop_front();
    checks++;
    if ({31'h0, irq} !== exp) $display("[TB] FAIL pre-reset irq: got %b, want %b", irq, exp[0]);
    else passed++;
    exp_q.push_back({24'h0, OUT_RESET});
    exp_q.push_back(32'h0);
    reset_n        = 1'b0;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = 3'd0;
    bus.writedata  = 32'hFF;
    tick();
    reset_n        = 1'b1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    exp = exp_q.pop_front();
    checks++;
    if ({24'h0, out_port} !== exp) $display("[TB] FAIL mid-op reset out_port: got %h, want %h", out_port, exp[7:0]);
    else passed++;
    exp = exp_q.pop_front();
    checks++;
    if ({31'h0, irq} !== exp) $display("[TB] FAIL mid-op reset irq: got %b, want %b", irq, exp[0]);
    else passed++;
    addr = '{3'd0, 3'd2, 3'd3, 3'd6, 3'd1, 3'd3};
    exp_q.push_back({24'h0, OUT_RESET});
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) tick(5);
      bus_read(addr[i], rd);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) $display("[TB] FAIL post-reset read %0d addr %0d: got %h, want %h", i, addr[i], rd, exp);
      else passed++;
    end
    exp_q.push_back(32'h0);
    exp_q.push_back({24'h0, OUT_RESET});
    exp_q.push_back(32'h0);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd7, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) $display("[TB] FAIL reserved read: got %h, want %h", rd, exp);
    else passed++;
    exp = exp_q.pop_front();
    checks++;
    if ({24'h0, out_port} !== exp) $display("[TB] FAIL reserved write side effect: got %h, want %h", out_port, exp[7:0]);
    else passed++;
    bus.chipselect = 1'b0;
    bus.address    = 3'd0;
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (bus.readdata !== exp) $display("[TB] FAIL deselected readdata: got %h, want %h", bus.readdata, exp);
    else passed++;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'h0;
    test_reset();
    test_output_aliases();
    test_edge_polarity();
    test_interrupt();
    test_clear_hit_collision();
    test_reset_mid_op();
    if (exp_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL scoreboard leftover: got %0d entries, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
